// File: rtl/enigma_pkg.sv
// Shared constants, rotor/reflector wiring and mod-26 helpers for the Enigma stream decoder.
package enigma_pkg;

    localparam int ALPHA  = 26;
    localparam int CHAR_W = 5;

    typedef logic [CHAR_W-1:0] wiring_t [ALPHA];

    typedef enum logic {
        S_UNKEYED = 1'b0,
        S_RUN     = 1'b1
    } state_t;

    function automatic logic [CHAR_W-1:0] add26(input logic [CHAR_W-1:0] a, input logic [CHAR_W-1:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[CHAR_W-1:0];
    endfunction

    function automatic logic [CHAR_W-1:0] sub26(input logic [CHAR_W-1:0] a, input logic [CHAR_W-1:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[CHAR_W-1:0];
    endfunction

    // Inverse tables are derived at elaboration so they can never drift from the forward wiring.
    function automatic wiring_t invert(input wiring_t w);
        wiring_t r;
        for (int i = 0; i < ALPHA; i++) r[w[i]] = CHAR_W'(i);
        return r;
    endfunction

    // III: BDFHJLCPRTXVZNYEIWGAKMUSQO
    localparam wiring_t W_R1 = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19,
                                 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0,
                                 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    // II: AJDKSIRUXBLHWTMCQGZNPYFVOE
    localparam wiring_t W_R2 = '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1,
                                 5'd11, 5'd7, 5'd22, 5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13,
                                 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
    // I: EKMFLGDQVZNTOWYHXUSPAIBRCJ
    localparam wiring_t W_R3 = '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25,
                                 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15,
                                 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
    // Reflector B: YRUHQSLDPXNGOKMIEBFZCWVJAT
    localparam wiring_t W_REF = '{5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23,
                                  5'd13, 5'd6, 5'd14, 5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25,
                                  5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

    localparam wiring_t W_R1_INV = invert(W_R1);
    localparam wiring_t W_R2_INV = invert(W_R2);
    localparam wiring_t W_R3_INV = invert(W_R3);

endpackage

// File: rtl/enigma_rotor_path.sv
// Combinational seven-stage letter path through three rotors and the reflector.
module enigma_rotor_path
    import enigma_pkg::*;
(
    input  logic [CHAR_W-1:0] c,
    input  logic [CHAR_W-1:0] p1,
    input  logic [CHAR_W-1:0] p2,
    input  logic [CHAR_W-1:0] p3,
    output logic [CHAR_W-1:0] y
);

    logic [CHAR_W-1:0] f1, f2, f3, rf, i3, i2;

    always_comb begin
        f1 = sub26(W_R1[add26(c,  p1)], p1);
        f2 = sub26(W_R2[add26(f1, p2)], p2);
        f3 = sub26(W_R3[add26(f2, p3)], p3);
        rf = W_REF[f3];
        i3 = sub26(W_R3_INV[add26(rf, p3)], p3);
        i2 = sub26(W_R2_INV[add26(i3, p2)], p2);
        y  = sub26(W_R1_INV[add26(i2, p1)], p1);
    end

endmodule

// File: rtl/enigma_stream_decoder.sv
// Flow-controlled Enigma decoder: steps an odometer rotor stack per legal letter, one-entry output register.
// state     | meaning
// S_UNKEYED | no key loaded since reset, input blocked
// S_RUN     | keyed, accepting and decoding letters
module enigma_stream_decoder
    import enigma_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [CHAR_W-1:0] key_r1,
    input  logic [CHAR_W-1:0] key_r2,
    input  logic [CHAR_W-1:0] key_r3,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_err,
    output logic [CHAR_W-1:0] r1_pos,
    output logic [CHAR_W-1:0] r2_pos,
    output logic [CHAR_W-1:0] r3_pos,
    output logic [CNT_W-1:0]  char_cnt
);

    state_t            state;
    logic              accept, legal, wrap1, wrap2;
    logic [CHAR_W-1:0] n1, n2, n3, enc;

    assign in_ready = (state == S_RUN) && !key_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign legal    = (in_char <= CHAR_W'(ALPHA - 1));

    // Rotors step before encoding, so the path sees the post-step positions.
    assign wrap1 = (r1_pos == CHAR_W'(ALPHA - 1));
    assign wrap2 = wrap1 && (r2_pos == CHAR_W'(ALPHA - 1));
    assign n1    = add26(r1_pos, CHAR_W'(1));
    assign n2    = wrap1 ? add26(r2_pos, CHAR_W'(1)) : r2_pos;
    assign n3    = wrap2 ? add26(r3_pos, CHAR_W'(1)) : r3_pos;

    enigma_rotor_path u_path (
        .c  (in_char),
        .p1 (n1),
        .p2 (n2),
        .p3 (n3),
        .y  (enc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_UNKEYED;
            out_valid <= 1'b0;
            out_char  <= '0;
            out_err   <= 1'b0;
            r1_pos    <= '0;
            r2_pos    <= '0;
            r3_pos    <= '0;
            char_cnt  <= '0;
        end else if (key_load) begin
            state     <= S_RUN;
            out_valid <= 1'b0;
            r1_pos    <= add26(key_r1, '0);
            r2_pos    <= add26(key_r2, '0);
            r3_pos    <= add26(key_r3, '0);
            char_cnt  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (legal) begin
                out_char <= enc;
                out_err  <= 1'b0;
                r1_pos   <= n1;
                r2_pos   <= n2;
                r3_pos   <= n3;
                char_cnt <= char_cnt + CNT_W'(1);
            end else begin
                out_char <= in_char;
                out_err  <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enigma_stream_decoder.sv
// Scoreboard bench for the Enigma stream decoder with an independent string-table reference model.
module tb_enigma_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [4:0]  key_r1, key_r2, key_r3;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_char;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_char;
    logic        out_err;
    logic [4:0]  r1_pos, r2_pos, r3_pos;
    logic [15:0] char_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [5:0] sb[$];
    int         rx[$];

    int m1, m2, m3, mcnt;

    string T_R1  = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    string T_R2  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string T_R3  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string T_REF = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    always #5 clk = ~clk;

    enigma_stream_decoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_r1    (key_r1),
        .key_r2    (key_r2),
        .key_r3    (key_r3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_err   (out_err),
        .r1_pos    (r1_pos),
        .r2_pos    (r2_pos),
        .r3_pos    (r3_pos),
        .char_cnt  (char_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int rot_fwd(input string w, input int c, input int p);
        int i;
        i = (c + p) % 26;
        return (w[i] - 65 - p + 26) % 26;
    endfunction

    function automatic int rot_inv(input string w, input int c, input int p);
        int t;
        t = (c + p) % 26;
        for (int j = 0; j < 26; j++)
            if (w[j] - 65 == t) return (j - p + 26) % 26;
        return 0;
    endfunction

    function automatic int model_encode(input int c);
        int a;
        a = rot_fwd(T_R1, c, m1);
        a = rot_fwd(T_R2, a, m2);
        a = rot_fwd(T_R3, a, m3);
        a = T_REF[a] - 65;
        a = rot_inv(T_R3, a, m3);
        a = rot_inv(T_R2, a, m2);
        a = rot_inv(T_R1, a, m1);
        return a;
    endfunction

    task automatic model_accept(input int c);
        if (c > 25) begin
            sb.push_back({1'b1, 5'(c)});
        end else begin
            m1 = (m1 + 1) % 26;
            if (m1 == 0) begin
                m2 = (m2 + 1) % 26;
                if (m2 == 0) m3 = (m3 + 1) % 26;
            end
            mcnt++;
            sb.push_back({1'b0, 5'(model_encode(c))});
        end
    endtask

    // Output monitor: every handshake pops one expected letter.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                rx.push_back(int'(out_char));
                if (sb.size() == 0) chk("sb_unexpected_output", int'(out_char), -1);
                else chk("sb_out", int'({out_err, out_char}), int'(sb.pop_front()));
            end
        end
    end

    task automatic send(input int c);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_char  = 5'(c);
            #1;
            if (in_ready) begin
                ok = 1'b1;
                model_accept(c);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                chk("latency_valid", int'(out_valid), 1);
                chk("r1_pos", int'(r1_pos), m1);
                chk("r2_pos", int'(r2_pos), m2);
                chk("r3_pos", int'(r3_pos), m3);
                chk("char_cnt", int'(char_cnt), mcnt);
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            chk("in_ready_timeout", 0, 1);
        end
    endtask

    task automatic do_key(input int a, input int b, input int c);
        @(negedge clk);
        key_load = 1'b1;
        key_r1 = 5'(a);
        key_r2 = 5'(b);
        key_r3 = 5'(c);
        @(posedge clk);
        #1;
        key_load = 1'b0;
        m1 = a % 26;
        m2 = b % 26;
        m3 = c % 26;
        mcnt = 0;
        sb.delete();
        rx.delete();
        chk("key_out_valid", int'(out_valid), 0);
        chk("key_cnt", int'(char_cnt), 0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    int enc_res[5];
    int t2_in[5] = '{1, 3, 25, 6, 14};

    initial begin
        rst = 1'b1; key_load = 1'b0; key_r1 = '0; key_r2 = '0; key_r3 = '0;
        in_valid = 1'b0; in_char = '0; out_ready = 1'b1;
        m1 = 0; m2 = 0; m3 = 0; mcnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: unkeyed decoder never accepts
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_char", int'(out_char), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_cnt", int'(char_cnt), 0);
        in_valid = 1'b1;
        in_char  = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("unkeyed_in_ready", int'(in_ready), 0);
            chk("unkeyed_out_valid", int'(out_valid), 0);
            chk("unkeyed_pos", int'({r1_pos, r2_pos, r3_pos}), 0);
        end
        in_valid = 1'b0;

        // T2: BDZGO decodes to AAAAA
        do_key(0, 0, 0);
        for (int i = 0; i < 5; i++) send(t2_in[i]);
        drain();
        chk("t2_rx_len", rx.size(), 5);
        for (int i = 0; i < rx.size() && i < 5; i++) chk("t2_plain", rx[i], 0);
        chk("t2_r1", int'(r1_pos), 5);
        chk("t2_cnt", int'(char_cnt), 5);

        // T3: encode then decode with the same key
        do_key(0, 0, 0);
        for (int i = 0; i < 5; i++) send(0);
        drain();
        chk("t3_rx_len", rx.size(), 5);
        for (int i = 0; i < 5; i++) enc_res[i] = (i < rx.size()) ? rx[i] : 0;
        for (int i = 0; i < 5; i++) chk("t3_cipher", enc_res[i], t2_in[i]);
        do_key(0, 0, 0);
        for (int i = 0; i < 5; i++) send(enc_res[i]);
        drain();
        for (int i = 0; i < rx.size() && i < 5; i++) chk("t3_roundtrip", rx[i], 0);

        // T4: backpressure holds the output and blocks input
        do_key(2, 7, 11);
        send(4);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = 5'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_char", int'(out_char), int'(sb.size() > 0 ? sb[0][4:0] : 5'd31));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send((i * 7 + 3) % 26);
        drain();
        chk("bp_rx_len", rx.size(), 9);

        // T5: odometer wrap
        do_key(25, 25, 25);
        send(7);
        chk("wrap_all", int'({r1_pos, r2_pos, r3_pos}), 0);
        do_key(25, 3, 0);
        send(7);
        chk("wrap_r1", int'(r1_pos), 0);
        chk("wrap_r2", int'(r2_pos), 4);
        chk("wrap_r3", int'(r3_pos), 0);
        drain();
        do_key(30, 28, 31);
        chk("key_mod_r1", int'(r1_pos), 4);
        chk("key_mod_r3", int'(r3_pos), 5);

        // T6: illegal letter passes through, then re-key mid-stream
        do_key(3, 1, 4);
        send(10);
        send(12);
        send(30);
        chk("illegal_char", int'(out_char), 30);
        chk("illegal_err", int'(out_err), 1);
        chk("illegal_cnt", int'(char_cnt), 2);
        send(5);
        chk("legal_err_clear", int'(out_err), 0);
        @(negedge clk);
        out_ready = 1'b0;
        key_load  = 1'b1;
        key_r1 = 5'd0; key_r2 = 5'd0; key_r3 = 5'd0;
        in_valid  = 1'b1;
        in_char   = 5'd5;
        #1;
        chk("rekey_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        m1 = 0; m2 = 0; m3 = 0; mcnt = 0;
        sb.delete();
        chk("rekey_out_valid", int'(out_valid), 0);
        chk("rekey_cnt", int'(char_cnt), 0);
        chk("rekey_pos", int'({r1_pos, r2_pos, r3_pos}), 0);
        out_ready = 1'b1;
        send(1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", n_chk, 0);
        $fatal(1, "timeout");
    end

endmodule
